ysyx_23060171_idu_ctrl: RTL and testbench

- Decode-stage controller that sits between the IFU and the EXU in the single-issue core.
- Accepts one fetched instruction per valid/ready handshake and holds it in a stage register.
- Decodes the opcode into the 3-bit immediate-type select and an illegal flag; these drive the immediate generator and downstream control.
- Presents the held instruction to the EXU with a valid/ready handshake and supports a flush.
- Keeps stall and retire performance counters.

---
 rtl/ysyx_23060171_idu_ctrl.sv | 96 +++++++++
 tb/tb_ysyx_23060171_idu_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060171_idu_ctrl.sv
// Decode-stage controller: single-entry stage between IFU and EXU with opcode
// decode (immediate select / illegal) and saturating stall/retire counters.
module ysyx_23060171_idu_ctrl #(
  parameter int XLEN     = 32,
  parameter bit ALLOW_SB = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      immtype,
  output logic            illegal,
  output logic [XLEN-1:0] stall_cnt,
  output logic [XLEN-1:0] retire_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t            state, state_nxt;
  logic              accept, fire, stall;
  logic [31:0]       inst_p0;
  logic [XLEN-1:0]   pc_p0;
  logic [2:0]        immtype_p0;
  logic              illegal_p0;
  logic [3:0]        dec;

  // Returns {illegal, immtype}; an illegal decode always reports immtype I.
  function automatic logic [3:0] decode(input logic [6:0] opcode);
    logic [3:0] r;
    unique case (opcode)
      7'b0010011, 7'b0000011,
      7'b1100111, 7'b1110011: r = 4'b0_000;
      7'b0110111, 7'b0010111: r = 4'b0_001;
      7'b1101111:             r = 4'b0_010;
      7'b0100011:             r = ALLOW_SB ? 4'b0_011 : 4'b1_000;
      7'b1100011:             r = ALLOW_SB ? 4'b0_100 : 4'b1_000;
      default:                r = 4'b1_000;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
    return (&v) ? v : v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    out_valid = (state == FULL);
    in_ready  = (state == EMPTY) | (out_ready & ~flush);
    fire      = out_valid & out_ready;
    stall     = out_valid & ~out_ready;
    accept    = in_valid & in_ready & ~flush;
    dec       = decode(in_inst[6:0]);
    state_nxt = state;
    if (flush)       state_nxt = EMPTY;
    else if (accept) state_nxt = FULL;
    else if (fire)   state_nxt = EMPTY;
  end

  // Stage p0: held instruction, decode results and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      inst_p0    <= NOP;
      pc_p0      <= '0;
      immtype_p0 <= 3'b000;
      illegal_p0 <= 1'b0;
      stall_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        inst_p0    <= in_inst;
        pc_p0      <= in_pc;
        immtype_p0 <= dec[2:0];
        illegal_p0 <= dec[3];
      end
      if (stall) stall_cnt  <= sat_inc(stall_cnt);
      if (fire)  retire_cnt <= sat_inc(retire_cnt);
    end
  end

  assign out_inst = inst_p0;
  assign out_pc   = pc_p0;
  assign immtype  = immtype_p0;
  assign illegal  = illegal_p0;

endmodule

// File: tb/tb_ysyx_23060171_idu_ctrl.sv
// Directed bench for the decode-stage controller; a second instance with
// ALLOW_SB=0 shares the stimulus to cover the store/branch-illegal variant.
module tb_ysyx_23060171_idu_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc;
  logic        in_ready, out_valid, illegal;
  logic [31:0] out_inst, out_pc, stall_cnt, retire_cnt;
  logic [2:0]  immtype;
  logic        in_ready2, out_valid2, illegal2;
  logic [31:0] out_inst2, out_pc2, stall_cnt2, retire_cnt2;
  logic [2:0]  immtype2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_23060171_idu_ctrl #(.XLEN(32), .ALLOW_SB(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .immtype(immtype), .illegal(illegal), .stall_cnt(stall_cnt),
    .retire_cnt(retire_cnt)
  );

  ysyx_23060171_idu_ctrl #(.XLEN(32), .ALLOW_SB(1'b0)) dut_nosb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid2),
    .out_ready(out_ready), .out_inst(out_inst2), .out_pc(out_pc2),
    .immtype(immtype2), .illegal(illegal2), .stall_cnt(stall_cnt2),
    .retire_cnt(retire_cnt2)
  );

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 32'h0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (out_inst !== 32'h13) begin n_fail++; $display("FAIL reset_out_inst got %h exp 00000013", out_inst); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
    n_checks++; if ({immtype, illegal} !== 4'b0) begin n_fail++; $display("FAIL reset_decode got %b%b exp 0000", immtype, illegal); end
    n_checks++; if (stall_cnt !== 0 || retire_cnt !== 0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt, retire_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    step();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_empty got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_inst = 32'h0010_0093; in_pc = 32'h8000_0000; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", out_valid); end
    n_checks++; if (immtype !== 3'b000 || illegal !== 1'b0) begin n_fail++; $display("FAIL single_decode got %b/%b exp 000/0", immtype, illegal); end
    n_checks++; if (out_pc !== 32'h8000_0000 || out_inst !== 32'h0010_0093) begin n_fail++; $display("FAIL single_data got %h/%h exp 80000000/00100093", out_pc, out_inst); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b exp 0", out_valid); end
    n_checks++; if (retire_cnt !== 32'd1) begin n_fail++; $display("FAIL single_retire got %0d exp 1", retire_cnt); end
  endtask

  task automatic test_opcode_sweep();
    logic [31:0] insts [5] = '{32'h0000_12B7, 32'h0000_006F, 32'h0011_2023, 32'h0000_0463, 32'h0000_007F};
    logic [3:0]  exp_sb [5] = '{4'b0_001, 4'b0_010, 4'b0_011, 4'b0_100, 4'b1_000};
    logic [3:0]  exp_ns [5] = '{4'b0_001, 4'b0_010, 4'b1_000, 4'b1_000, 4'b1_000};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_inst = insts[i]; in_pc = 32'h1000 + 32'(i * 4);
      step();
      in_valid = 1'b0;
      n_checks++; if ({illegal, immtype} !== exp_sb[i]) begin n_fail++; $display("FAIL sweep_sb inst=%h got %b exp %b", insts[i], {illegal, immtype}, exp_sb[i]); end
      n_checks++; if ({illegal2, immtype2} !== exp_ns[i]) begin n_fail++; $display("FAIL sweep_nosb inst=%h got %b exp %b", insts[i], {illegal2, immtype2}, exp_ns[i]); end
      n_checks++; if (out_valid2 !== 1'b1 || out_inst2 !== insts[i]) begin n_fail++; $display("FAIL sweep_passthru got %b/%h exp 1/%h", out_valid2, out_inst2, insts[i]); end
      step();
    end
    n_checks++; if (retire_cnt !== 32'd6) begin n_fail++; $display("FAIL sweep_retire got %0d exp 6", retire_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1; in_inst = 32'h0000_12B7; in_pc = 32'h100; out_ready = 1'b0;
    step();
    in_inst = 32'h0010_0093; in_pc = 32'h104;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got %b exp 0", i, in_ready); end
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== 32'h0000_12B7 || immtype !== 3'b001) begin
        n_fail++; $display("FAIL bp_stable cyc=%0d got %b/%h/%h/%b exp 1/00000100/000012b7/001", i, out_valid, out_pc, out_inst, immtype);
      end
      step();
    end
    n_checks++; if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL bp_stall_cnt got %0d exp 5", stall_cnt); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_checks++; if (retire_cnt !== 32'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got %0d/%b exp 1/0", retire_cnt, out_valid); end
    n_checks++; if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL bp_stall_hold got %0d exp 5", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = 32'h0000_0013 | (32'(i) << 20); in_pc = 32'h200 + 32'(i * 4);
      step();
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(i * 4)) begin
        n_fail++; $display("FAIL b2b cyc=%0d got %b/%h exp 1/%h", i, out_valid, out_pc, 32'h200 + 32'(i * 4));
      end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cyc=%0d got %b exp 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    n_checks++; if (retire_cnt !== 32'd4 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_retire got %0d/%b exp 4/0", retire_cnt, out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_inst = 32'h0000_006F; in_pc = 32'h300; out_ready = 1'b0;
    step();
    in_inst = 32'h0000_12B7; in_pc = 32'h304; flush = 1'b1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty got %b exp 0", out_valid); end
    n_checks++; if (out_pc !== 32'h300) begin n_fail++; $display("FAIL flush_no_capture got %h exp 00000300", out_pc); end
    n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL flush_retire got %0d exp 0", retire_cnt); end
    // Flush while the EXU accepts: the handshake still retires, new input dropped.
    in_valid = 1'b1; in_inst = 32'h0000_0463; in_pc = 32'h400;
    step();
    in_pc = 32'h404; out_ready = 1'b1; flush = 1'b1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_rdy_hs got %b exp 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || retire_cnt !== 32'd1 || out_pc !== 32'h400) begin
      n_fail++; $display("FAIL flush_hs got %b/%0d/%h exp 0/1/00000400", out_valid, retire_cnt, out_pc);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    in_valid = 1'b1; in_inst = 32'h0011_2023; in_pc = 32'h500; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    n_checks++; if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL mid_stall_cnt got %0d exp 3", stall_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || stall_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_rst got %b/%0d exp 0/0", out_valid, stall_cnt); end
    n_checks++; if (out_inst !== 32'h13 || out_pc !== 32'h0 || immtype !== 3'b000) begin
      n_fail++; $display("FAIL mid_rst_data got %h/%h/%b exp 00000013/0/000", out_inst, out_pc, immtype);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_opcode_sweep();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
